priority_decoder: RTL and testbench

Registered index-to-one-hot decoder: the inverse of the 32-way priority encoder. It accepts a 5-bit bit index over a valid/ready handshake and returns the corresponding one-hot 32-bit vector over a second valid/ready handshake. A two-entry skid buffer sustains one beat per cycle under backpressure. It sits downstream of encoded request/arbitration logic, where an index must be turned back into a per-line select, grant or clear vector.

---
 rtl/priority_decoder.sv | 118 +++++++++++
 tb/tb_priority_decoder.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/priority_decoder.sv
// priority_decoder: registered 5-bit-index to one-hot decoder with a
// two-entry skid buffer on a valid/ready stream. Optional sticky delivery
// mask is built when PRIORITY_DECODER_MASK_EN is defined.
module priority_decoder #(
  parameter  int unsigned OUT_W = 32,
  localparam int unsigned IDX_W = $clog2(OUT_W)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [IDX_W-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic [OUT_W-1:0] data_o,
  output logic             valid_o,
  input  logic             ready_i
`ifdef PRIORITY_DECODER_MASK_EN
  ,
  output logic [OUT_W-1:0] mask_o,
  input  logic             mask_clr_i
`endif
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] TWO   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic [OUT_W-1:0] skid_q, skid_d;
  logic [OUT_W-1:0] dec;
  logic             in_xfer, out_xfer;

  // Out-of-range indices (non-power-of-2 OUT_W) decode to all zeros.
  function automatic logic [OUT_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [OUT_W-1:0] v;
    v = '0;
    for (int unsigned k = 0; k < OUT_W; k++) begin
      if (32'(idx) == k) v[k] = 1'b1;
    end
    return v;
  endfunction

  assign ready_o  = (state_q != TWO);
  assign valid_o  = (state_q != EMPTY);
  assign data_o   = out_q;
  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = valid_o && ready_i;

  // Decode only for transfers, so data_i is never sampled without valid_i.
  always_comb begin
    dec = '0;
    if (in_xfer) dec = onehot(data_i);
  end

  // Occupancy sequencing between the output register and the skid register.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          out_d   = dec;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          out_d = dec;
        end else if (in_xfer) begin
          skid_d  = dec;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          out_d   = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // State and storage registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= EMPTY;
      out_q   <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PRIORITY_DECODER_MASK_EN
  logic [OUT_W-1:0] mask_q, mask_d;

  // Clear is applied before the set so a bit delivered on the clearing edge survives.
  always_comb begin
    mask_d = mask_clr_i ? '0 : mask_q;
    if (out_xfer) mask_d = mask_d | out_q;
  end

  // Sticky delivery mask register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) mask_q <= '0;
    else         mask_q <= mask_d;
  end

  assign mask_o = mask_q;
`endif

endmodule

// File: tb/tb_priority_decoder.sv
// Testbench for priority_decoder: queue-based model checked every cycle,
// directed vectors with literal expectations, random traffic, async reset,
// an OUT_W=20 instance, and mask checks when PRIORITY_DECODER_MASK_EN is set.
module tb_priority_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  data_i = '0;
  logic        valid_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        ready_o, valid_o;
  logic [31:0] data_o;

  logic [4:0]  d20_i = '0;
  logic        v20_i = 1'b0;
  logic        r20_i = 1'b0;
  logic        r20_o, v20_o;
  logic [19:0] d20_o;

`ifdef PRIORITY_DECODER_MASK_EN
  logic [31:0] mask_o;
  logic        mask_clr = 1'b0;
  logic [19:0] mask20_o;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  priority_decoder #(.OUT_W(32)) dut (
    .clk_i(clk), .rst_ni(rst_n), .data_i(data_i), .valid_i(valid_i),
    .ready_o(ready_o), .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
`ifdef PRIORITY_DECODER_MASK_EN
    , .mask_o(mask_o), .mask_clr_i(mask_clr)
`endif
  );

  priority_decoder #(.OUT_W(20)) dut20 (
    .clk_i(clk), .rst_ni(rst_n), .data_i(d20_i), .valid_i(v20_i),
    .ready_o(r20_o), .data_o(d20_o), .valid_o(v20_o), .ready_i(r20_i)
`ifdef PRIORITY_DECODER_MASK_EN
    , .mask_o(mask20_o), .mask_clr_i(1'b0)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] expect_vec(input int unsigned idx, input int unsigned w);
    return (idx < w) ? (64'd1 << idx) : 64'd0;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model: a FIFO of accepted indices, capacity two.
  int unsigned q[$];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      automatic bit out_x = (q.size() > 0) && ready_i;
      automatic bit in_x  = valid_i && (q.size() < 2);
      if (out_x) void'(q.pop_front());
      if (in_x) q.push_back(int'(data_i));
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 64'(valid_o), 64'd0);
      chk("rst_ready", 64'(ready_o), 64'd1);
      chk("rst_data", 64'(data_o), 64'd0);
    end else begin
      chk("valid_o", 64'(valid_o), 64'(q.size() != 0));
      chk("ready_o", 64'(ready_o), 64'(q.size() < 2));
      if (q.size() != 0) chk("data_o", 64'(data_o), expect_vec(q[0], 32));
    end
  end

  initial begin
    // Reset state
    #1;
    chk("reset_valid_lit", 64'(valid_o), 64'd0);
    chk("reset_ready_lit", 64'(ready_o), 64'd1);
    chk("reset_data_lit", 64'(data_o), 64'd0);
    tick(); tick();
    rst_n = 1'b1;

    // Back-to-back 0,1,17,31 with ready_i high
    ready_i = 1'b1; valid_i = 1'b1; data_i = 5'd0;
    tick();
    chk("b2b_0", 64'(data_o), 64'h0000_0001);
    data_i = 5'd1;
    tick();
    chk("b2b_1", 64'(data_o), 64'h0000_0002);
    data_i = 5'd17;
    tick();
    chk("b2b_17", 64'(data_o), 64'h0002_0000);
    data_i = 5'd31;
    tick();
    chk("b2b_31", 64'(data_o), 64'h8000_0000);
    chk("b2b_ready", 64'(ready_o), 64'd1);
    chk("b2b_valid", 64'(valid_o), 64'd1);
    valid_i = 1'b0;
    tick();
    chk("b2b_drain", 64'(valid_o), 64'd0);

    // Backpressure: 3 then 4 with ready_i low
    ready_i = 1'b0; valid_i = 1'b1; data_i = 5'd3;
    tick();
    chk("bp_first_ready", 64'(ready_o), 64'd1);
    data_i = 5'd4;
    tick();
    chk("bp_full_ready", 64'(ready_o), 64'd0);
    chk("bp_hold_data", 64'(data_o), 64'h0000_0008);
    data_i = 5'd9;                     // offered while full: must not be taken
    tick();
    chk("bp_stall_data", 64'(data_o), 64'h0000_0008);
    valid_i = 1'b0; ready_i = 1'b1;
    tick();
    chk("bp_skid_data", 64'(data_o), 64'h0000_0010);
    chk("bp_ready_back", 64'(ready_o), 64'd1);
    tick();
    chk("bp_empty", 64'(valid_o), 64'd0);

    // Full with valid_i and ready_i high: only output transfer that edge
    ready_i = 1'b0; valid_i = 1'b1; data_i = 5'd5;
    tick(); data_i = 5'd6;
    tick(); data_i = 5'd7; ready_i = 1'b1;
    tick();
    chk("full_out_only", 64'(data_o), 64'h0000_0040);
    chk("full_ready_again", 64'(ready_o), 64'd1);
    tick();
    chk("full_next_accept", 64'(data_o), 64'h0000_0080);
    valid_i = 1'b0;
    tick();

    // Random traffic checked by the per-cycle compare
    for (int i = 0; i < 12000; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 2) != 0);
      data_i  = 5'($urandom_range(0, 31));
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    tick(); tick(); tick();
    chk("rand_drained_model", 64'(q.size()), 64'd0);
    chk("rand_drained_dut", 64'(valid_o), 64'd0);

    // Async reset while in TWO
    ready_i = 1'b0; valid_i = 1'b1; data_i = 5'd12;
    tick(); data_i = 5'd13;
    tick();
    valid_i = 1'b0;
    chk("pre_rst_full", 64'(ready_o), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(valid_o), 64'd0);
    chk("arst_data", 64'(data_o), 64'd0);
    chk("arst_ready", 64'(ready_o), 64'd1);
    tick(); tick();
    rst_n = 1'b1; ready_i = 1'b1;
    tick();
    chk("arst_no_stale", 64'(valid_o), 64'd0);
    tick();
    chk("arst_no_stale2", 64'(valid_o), 64'd0);

`ifdef PRIORITY_DECODER_MASK_EN
    chk("mask_reset", 64'(mask_o), 64'd0);
    valid_i = 1'b1; data_i = 5'd2;
    tick(); data_i = 5'd5;
    tick(); data_i = 5'd2;
    tick(); valid_i = 1'b0;
    tick();
    chk("mask_2_5_2", 64'(mask_o), 64'h0000_0024);
    valid_i = 1'b1; data_i = 5'd9;
    tick();
    valid_i = 1'b0; mask_clr = 1'b1;
    tick();
    chk("mask_clr_set", 64'(mask_o), 64'h0000_0200);
    tick();
    mask_clr = 1'b0;
    chk("mask_clr_only", 64'(mask_o), 64'd0);
    tick();
    chk("mask_idle", 64'(mask_o), 64'd0);
`endif

    // OUT_W = 20: out-of-range index still transfers, as zero
    r20_i = 1'b1; v20_i = 1'b1; d20_i = 5'd25;
    tick();
    chk("w20_oor_valid", 64'(v20_o), 64'd1);
    chk("w20_oor_data", 64'(d20_o), 64'd0);
    chk("w20_oor_ready", 64'(r20_o), 64'd1);
    d20_i = 5'd19;
    tick();
    chk("w20_19", 64'(d20_o), 64'h8_0000);
    v20_i = 1'b0;
    tick();
    chk("w20_empty", 64'(v20_o), 64'd0);
    r20_i = 1'b0; v20_i = 1'b1; d20_i = 5'd25;
    tick(); d20_i = 5'd0;
    tick(); v20_i = 1'b0;
    chk("w20_full", 64'(r20_o), 64'd0);
    chk("w20_hold", 64'(d20_o), 64'd0);
    r20_i = 1'b1;
    tick();
    chk("w20_skid", 64'(d20_o), 64'h0_0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
